// File: rtl/ram_port_arbiter_if.sv
// Signal bundle between the two RAM requesters, the arbiter and the RAM.
// Names follow the arbiter's point of view: i_ = into the arbiter, o_ = out of it.
`ifndef RAM_NONE
`define RAM_NONE  2'b00
`endif
`ifndef RAM_READ
`define RAM_READ  2'b01
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'b10
`endif

interface ram_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_f_req;
  logic [AW-1:0] i_f_addr;
  logic          o_f_gnt;
  logic          o_f_valid;
  logic [DW-1:0] o_f_data;
  logic          i_d_req;
  logic [1:0]    i_d_action;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata;
  logic          o_d_gnt;
  logic          o_d_valid;
  logic [DW-1:0] o_d_rdata;
  logic [1:0]    o_ram_action;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;
  logic          o_busy;

  // Requester/RAM side.
  modport master (
    output i_f_req, i_f_addr, i_d_req, i_d_action, i_d_addr, i_d_wdata, i_ram_rdata,
    input  o_f_gnt, o_f_valid, o_f_data, o_d_gnt, o_d_valid, o_d_rdata,
    input  o_ram_action, o_ram_addr, o_ram_wdata, o_busy
  );

  // Arbiter side.
  modport slave (
    input  i_f_req, i_f_addr, i_d_req, i_d_action, i_d_addr, i_d_wdata, i_ram_rdata,
    output o_f_gnt, o_f_valid, o_f_data, o_d_gnt, o_d_valid, o_d_rdata,
    output o_ram_action, o_ram_addr, o_ram_wdata, o_busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between a read-only fetch requester and a read/write data requester.
// One transaction at a time, alternating priority on contention; all outputs registered.
`ifndef RAM_NONE
`define RAM_NONE  2'b00
`endif
`ifndef RAM_READ
`define RAM_READ  2'b01
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'b10
`endif

module ram_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ram_port_arbiter_if.slave    io_bus
);

  typedef enum logic [1:0] {StIdle, StCmd, StWait, StResp} state_e;

  state_e     r_state;
  logic       r_owner_data;
  logic       r_last_data;
  logic [3:0] r_cnt;

  logic w_f_qual;
  logic w_d_qual;
  logic w_pick_data;

  assign w_f_qual    = io_bus.i_f_req;
  assign w_d_qual    = io_bus.i_d_req &&
                       (io_bus.i_d_action == `RAM_READ || io_bus.i_d_action == `RAM_WRITE);
  // On a tie the port that did not own the previous transaction wins.
  assign w_pick_data = w_d_qual && (!w_f_qual || !r_last_data);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state             <= StIdle;
      r_owner_data        <= 1'b0;
      r_last_data         <= 1'b0;
      r_cnt               <= 4'd0;
      io_bus.o_f_gnt      <= 1'b0;
      io_bus.o_f_valid    <= 1'b0;
      io_bus.o_f_data     <= {DW{1'b0}};
      io_bus.o_d_gnt      <= 1'b0;
      io_bus.o_d_valid    <= 1'b0;
      io_bus.o_d_rdata    <= {DW{1'b0}};
      io_bus.o_ram_action <= `RAM_NONE;
      io_bus.o_ram_addr   <= {AW{1'b0}};
      io_bus.o_ram_wdata  <= {DW{1'b0}};
      io_bus.o_busy       <= 1'b0;
    end else begin
      io_bus.o_f_gnt   <= 1'b0;
      io_bus.o_d_gnt   <= 1'b0;
      io_bus.o_f_valid <= 1'b0;
      io_bus.o_d_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_f_qual || w_d_qual) begin
            r_owner_data        <= w_pick_data;
            r_last_data         <= w_pick_data;
            io_bus.o_f_gnt      <= !w_pick_data;
            io_bus.o_d_gnt      <= w_pick_data;
            io_bus.o_ram_action <= w_pick_data ? io_bus.i_d_action : `RAM_READ;
            io_bus.o_ram_addr   <= w_pick_data ? io_bus.i_d_addr : io_bus.i_f_addr;
            io_bus.o_ram_wdata  <= w_pick_data ? io_bus.i_d_wdata : {DW{1'b0}};
            io_bus.o_busy       <= 1'b1;
            r_state             <= StCmd;
          end
        end
        StCmd: begin
          io_bus.o_ram_action <= `RAM_NONE;
          // Only the data port can write, so a write always completes on the data side.
          if (io_bus.o_ram_action == `RAM_WRITE) begin
            io_bus.o_d_valid <= 1'b1;
            r_state          <= StResp;
          end else begin
            r_cnt   <= 4'(RAM_LAT);
            r_state <= StWait;
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_owner_data) begin
              io_bus.o_d_rdata <= io_bus.i_ram_rdata;
              io_bus.o_d_valid <= 1'b1;
            end else begin
              io_bus.o_f_data  <= io_bus.i_ram_rdata;
              io_bus.o_f_valid <= 1'b1;
            end
            r_state <= StResp;
          end
        end
        StResp: begin
          io_bus.o_busy <= 1'b0;
          r_state       <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: two arbiters (RAM_LAT 1 and 3), each with a small RAM model.
`ifndef RAM_NONE
`define RAM_NONE  2'b00
`endif
`ifndef RAM_READ
`define RAM_READ  2'b01
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'b10
`endif

module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(32), .DW(32)) if1 ();
  ram_port_arbiter_if #(.AW(32), .DW(32)) if3 ();

  ram_port_arbiter #(.AW(32), .DW(32), .RAM_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .io_bus(if1)
  );
  ram_port_arbiter #(.AW(32), .DW(32), .RAM_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .io_bus(if3)
  );

  int checks = 0;
  int failures = 0;

  // RAM contents: seed until written; 16 words selected by addr[5:2].
  bit   [31:0] seed [16];
  logic [31:0] mem1 [16];
  bit          wv1  [16];
  logic [31:0] refm [16];
  bit          refv [16];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  function automatic logic [31:0] ram1_word(input logic [31:0] a);
    return wv1[a[5:2]] ? mem1[a[5:2]] : seed[a[5:2]];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return refv[a[5:2]] ? refm[a[5:2]] : seed[a[5:2]];
  endfunction

  // Read data is only meaningful exactly RAM_LAT cycles after the command; junk otherwise.
  always @(posedge clk) begin
    if (if1.o_ram_action == `RAM_WRITE) begin
      mem1[if1.o_ram_addr[5:2]] <= if1.o_ram_wdata;
      wv1[if1.o_ram_addr[5:2]]  <= 1'b1;
    end
    pipe1    <= (if1.o_ram_action == `RAM_READ) ? ram1_word(if1.o_ram_addr) : $urandom;
    pipe3[0] <= (if3.o_ram_action == `RAM_READ) ? seed[if3.o_ram_addr[5:2]] : $urandom;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign if1.i_ram_rdata = pipe1;
  assign if3.i_ram_rdata = pipe3[2];

  task automatic idle_inputs();
    if1.i_f_req = 1'b0; if1.i_f_addr = '0; if1.i_d_req = 1'b0;
    if1.i_d_action = `RAM_NONE; if1.i_d_addr = '0; if1.i_d_wdata = '0;
    if3.i_f_req = 1'b0; if3.i_f_addr = '0; if3.i_d_req = 1'b0;
    if3.i_d_action = `RAM_NONE; if3.i_d_addr = '0; if3.i_d_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] w;
    do_reset();
    checks++; if ({if1.o_f_gnt, if1.o_f_valid, if1.o_d_gnt, if1.o_d_valid, if1.o_busy} !== 5'b0)
      begin failures++; $display("FAIL rst_flags: got %b want 00000",
        {if1.o_f_gnt, if1.o_f_valid, if1.o_d_gnt, if1.o_d_valid, if1.o_busy}); end
    checks++; if (if1.o_ram_action !== `RAM_NONE)
      begin failures++; $display("FAIL rst_action: got %b want 00", if1.o_ram_action); end
    checks++; if ({if1.o_ram_addr, if1.o_ram_wdata, if1.o_f_data, if1.o_d_rdata} !== 128'h0)
      begin failures++; $display("FAIL rst_regs: got %h/%h/%h/%h want 0", if1.o_ram_addr,
        if1.o_ram_wdata, if1.o_f_data, if1.o_d_rdata); end
    // Complete one fetch so o_f_data holds something, then start another and reset in CMD.
    if1.i_f_req = 1'b1; if1.i_f_addr = 32'h4;
    for (int c = 0; c < 10 && !if1.o_f_valid; c++) @(negedge clk);
    if1.i_f_req = 1'b0;
    w = seed[1];
    checks++; if (if1.o_f_data !== w)
      begin failures++; $display("FAIL rst_pre_fetch: got %h want %h", if1.o_f_data, w); end
    @(negedge clk);
    if1.i_f_req = 1'b1; if1.i_f_addr = 32'h8;
    @(negedge clk);
    if1.i_f_req = 1'b0;
    checks++; if (if1.o_f_gnt !== 1'b1 || if1.o_ram_action !== `RAM_READ)
      begin failures++; $display("FAIL rst_pre_cmd: got gnt=%b act=%b want 1/01",
        if1.o_f_gnt, if1.o_ram_action); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({if1.o_f_gnt, if1.o_f_valid, if1.o_busy} !== 3'b0 || if1.o_ram_action !== `RAM_NONE)
      begin failures++; $display("FAIL rst_async_ctl: got gnt=%b val=%b busy=%b act=%b want 0",
        if1.o_f_gnt, if1.o_f_valid, if1.o_busy, if1.o_ram_action); end
    checks++; if ({if1.o_ram_addr, if1.o_f_data} !== 64'h0)
      begin failures++; $display("FAIL rst_async_regs: got addr=%h fdata=%h want 0",
        if1.o_ram_addr, if1.o_f_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (if1.o_f_valid !== 1'b0 || if1.o_busy !== 1'b0)
        begin failures++; $display("FAIL rst_no_valid: got val=%b busy=%b want 0/0",
          if1.o_f_valid, if1.o_busy); end
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    if1.i_f_req = 1'b1; if1.i_f_addr = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (if1.o_f_gnt !== (k == 1) || if1.o_d_gnt !== 1'b0)
        begin failures++; $display("FAIL sf_gnt k=%0d: got f=%b d=%b want %b/0", k,
          if1.o_f_gnt, if1.o_d_gnt, k == 1); end
      checks++; if (if1.o_f_valid !== (k == 3) || if1.o_d_valid !== 1'b0)
        begin failures++; $display("FAIL sf_valid k=%0d: got f=%b d=%b want %b/0", k,
          if1.o_f_valid, if1.o_d_valid, k == 3); end
      if (k == 1) begin
        checks++; if (if1.o_ram_action !== `RAM_READ || if1.o_ram_addr !== 32'h10)
          begin failures++; $display("FAIL sf_cmd: got act=%b addr=%h want 01/10",
            if1.o_ram_action, if1.o_ram_addr); end
      end
      if (k >= 3) begin
        checks++; if (if1.o_f_data !== 32'hDEADBEEF)
          begin failures++; $display("FAIL sf_data k=%0d: got %h want deadbeef", k,
            if1.o_f_data); end
        if1.i_f_req = 1'b0;
      end
    end
  endtask

  task automatic test_data_write();
    refm[8] = 32'h12345678; refv[8] = 1'b1;
    if1.i_d_req = 1'b1; if1.i_d_action = `RAM_WRITE;
    if1.i_d_addr = 32'h20; if1.i_d_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if (if1.o_d_gnt !== 1'b1 || if1.o_ram_action !== `RAM_WRITE ||
                  if1.o_ram_addr !== 32'h20 || if1.o_ram_wdata !== 32'h12345678)
      begin failures++; $display("FAIL dw_cmd: got gnt=%b act=%b addr=%h wd=%h want 1/10/20/12345678",
        if1.o_d_gnt, if1.o_ram_action, if1.o_ram_addr, if1.o_ram_wdata); end
    @(negedge clk);
    checks++; if (if1.o_d_valid !== 1'b1 || if1.o_ram_action !== `RAM_NONE || if1.o_f_valid !== 1'b0)
      begin failures++; $display("FAIL dw_resp: got dval=%b act=%b fval=%b want 1/00/0",
        if1.o_d_valid, if1.o_ram_action, if1.o_f_valid); end
    checks++; if (if1.o_d_rdata !== 32'h0)
      begin failures++; $display("FAIL dw_rdata: got %h want 0", if1.o_d_rdata); end
    if1.i_d_req = 1'b0;
    @(negedge clk);
    checks++; if (if1.o_d_valid !== 1'b0 || if1.o_busy !== 1'b0)
      begin failures++; $display("FAIL dw_done: got val=%b busy=%b want 0/0",
        if1.o_d_valid, if1.o_busy); end
  endtask

  task automatic test_ignored();
    if1.i_d_req = 1'b1; if1.i_d_action = `RAM_NONE; if1.i_d_addr = 32'h30;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({if1.o_f_gnt, if1.o_d_gnt, if1.o_busy} !== 3'b0)
        begin failures++; $display("FAIL ign c=%0d: got gnt=%b%b busy=%b want 0", c,
          if1.o_f_gnt, if1.o_d_gnt, if1.o_busy); end
    end
    if1.i_d_req = 1'b0;
  endtask

  task automatic test_contention();
    int order[$];
    int outstanding = 0;
    int last_valid = -100;
    do_reset();
    refm[2] = 32'hA5A50001; refv[2] = 1'b1;
    if1.i_f_req = 1'b1; if1.i_f_addr = 32'h0C;
    if1.i_d_req = 1'b1; if1.i_d_action = `RAM_WRITE;
    if1.i_d_addr = 32'h08; if1.i_d_wdata = 32'hA5A50001;
    for (int c = 1; c <= 40 && order.size() < 4; c++) begin
      @(negedge clk);
      if (if1.o_f_gnt || if1.o_d_gnt) begin
        checks++; if (outstanding != 0 || (if1.o_f_gnt && if1.o_d_gnt))
          begin failures++; $display("FAIL ct_overlap c=%0d: got outstanding=%0d gnt=%b%b want 0",
            c, outstanding, if1.o_f_gnt, if1.o_d_gnt); end
        if (order.size() > 0) begin
          checks++; if (c != last_valid + 2)
            begin failures++; $display("FAIL ct_gap: got gnt at %0d want %0d", c,
              last_valid + 2); end
        end
        order.push_back(if1.o_d_gnt ? 1 : 0);
        outstanding = 1;
      end
      if (if1.o_f_valid || if1.o_d_valid) begin
        outstanding = 0;
        last_valid = c;
      end
    end
    checks++; if (order.size() != 4)
      begin failures++; $display("FAIL ct_count: got %0d grants want 4", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      checks++; if (order[i] != ((i % 2 == 0) ? 1 : 0))
        begin failures++; $display("FAIL ct_order[%0d]: got data=%0d want %0d", i, order[i],
          (i % 2 == 0) ? 1 : 0); end
    end
    idle_inputs();
    for (int c = 0; c < 10 && if1.o_busy; c++) @(negedge clk);
  endtask

  task automatic test_random(input int n);
    bit pf = 1'b0, pd = 1'b0, own_d, is_rd, last_d = 1'b0;
    logic [31:0] fa = '0, da = '0, dw = '0, exp_a, exp_word, exp_f = '0, exp_d = '0, r;
    logic [1:0] dact = `RAM_READ, exp_act;
    int lat;
    do_reset();
    @(negedge clk);
    for (int t = 0; t < n; t++) begin
      if (!pf && (!pd || $urandom_range(0, 1) == 1)) begin
        r = $urandom; fa = {r[31:2], 2'b00}; pf = 1'b1;
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        r = $urandom; da = {r[31:2], 2'b00}; dw = $urandom;
        dact = ($urandom_range(0, 1) == 1) ? `RAM_READ : `RAM_WRITE; pd = 1'b1;
      end
      if1.i_f_req = pf; if1.i_f_addr = fa;
      if1.i_d_req = pd ? 1'b1 : ($urandom_range(0, 3) == 0);
      if1.i_d_action = pd ? dact : `RAM_NONE;
      if1.i_d_addr = da; if1.i_d_wdata = dw;
      own_d = pd && (!pf || !last_d);
      last_d = own_d;
      exp_act = own_d ? dact : `RAM_READ;
      exp_a = own_d ? da : fa;
      is_rd = (exp_act == `RAM_READ);
      exp_word = is_rd ? ref_word(exp_a) : 32'h0;
      if (!is_rd) begin refm[exp_a[5:2]] = dw; refv[exp_a[5:2]] = 1'b1; end
      lat = is_rd ? 3 : 2;
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        if (k == 1) begin
          checks++; if (if1.o_f_gnt !== !own_d || if1.o_d_gnt !== own_d)
            begin failures++; $display("FAIL rnd_gnt t=%0d: got f=%b d=%b want %b/%b", t,
              if1.o_f_gnt, if1.o_d_gnt, !own_d, own_d); end
          checks++; if (if1.o_ram_action !== exp_act || if1.o_ram_addr !== exp_a)
            begin failures++; $display("FAIL rnd_cmd t=%0d: got %b/%h want %b/%h", t,
              if1.o_ram_action, if1.o_ram_addr, exp_act, exp_a); end
          if (!is_rd) begin
            checks++; if (if1.o_ram_wdata !== dw)
              begin failures++; $display("FAIL rnd_wdata t=%0d: got %h want %h", t,
                if1.o_ram_wdata, dw); end
          end
          if (own_d) begin if1.i_d_addr = $urandom; if1.i_d_wdata = $urandom; end
          else if1.i_f_addr = $urandom;
        end else begin
          checks++; if ({if1.o_f_gnt, if1.o_d_gnt} !== 2'b00)
            begin failures++; $display("FAIL rnd_gnt_extra t=%0d k=%0d: got %b%b want 00", t, k,
              if1.o_f_gnt, if1.o_d_gnt); end
        end
        checks++; if (if1.o_f_valid !== (!own_d && k == lat) || if1.o_d_valid !== (own_d && k == lat)
                      || if1.o_busy !== 1'b1)
          begin failures++; $display("FAIL rnd_valid t=%0d k=%0d: got f=%b d=%b busy=%b want %b/%b/1",
            t, k, if1.o_f_valid, if1.o_d_valid, if1.o_busy, !own_d && k == lat,
            own_d && k == lat); end
        if (k == lat) begin
          if (is_rd) begin
            if (own_d) exp_d = exp_word;
            else exp_f = exp_word;
          end
          checks++; if (if1.o_f_data !== exp_f || if1.o_d_rdata !== exp_d)
            begin failures++; $display("FAIL rnd_data t=%0d: got f=%h d=%h want f=%h d=%h", t,
              if1.o_f_data, if1.o_d_rdata, exp_f, exp_d); end
        end
      end
      if (own_d) begin pd = 1'b0; if1.i_d_req = 1'b0; end
      else begin pf = 1'b0; if1.i_f_req = 1'b0; end
      @(negedge clk);
      checks++; if ({if1.o_busy, if1.o_f_gnt, if1.o_d_gnt} !== 3'b000)
        begin failures++; $display("FAIL rnd_idle t=%0d: got busy=%b gnt=%b%b want 0", t,
          if1.o_busy, if1.o_f_gnt, if1.o_d_gnt); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    if3.i_f_req = 1'b1; if3.i_f_addr = 32'h08;
    @(negedge clk);
    if3.i_f_req = 1'b0;
    checks++; if (if3.o_f_gnt !== 1'b1)
      begin failures++; $display("FAIL rw_gnt: got %b want 1", if3.o_f_gnt); end
    @(negedge clk);
    checks++; if (if3.o_busy !== 1'b1 || if3.o_ram_action !== `RAM_NONE)
      begin failures++; $display("FAIL rw_wait: got busy=%b act=%b want 1/00", if3.o_busy,
        if3.o_ram_action); end
    #2 rst = 1'b1;
    #1;
    checks++; if (if3.o_busy !== 1'b0 || if3.o_f_valid !== 1'b0)
      begin failures++; $display("FAIL rw_async: got busy=%b val=%b want 0/0", if3.o_busy,
        if3.o_f_valid); end
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (if3.o_f_valid !== 1'b0 || if3.o_busy !== 1'b0)
        begin failures++; $display("FAIL rw_aborted c=%0d: got val=%b busy=%b want 0/0", c,
          if3.o_f_valid, if3.o_busy); end
    end
    if3.i_f_req = 1'b1; if3.i_f_addr = 32'h40;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (if3.o_f_gnt !== (k == 1) || if3.o_f_valid !== (k == 5))
        begin failures++; $display("FAIL rw_new k=%0d: got gnt=%b val=%b want %b/%b", k,
          if3.o_f_gnt, if3.o_f_valid, k == 1, k == 5); end
      if (k == 5) begin
        checks++; if (if3.o_f_data !== seed[0])
          begin failures++; $display("FAIL rw_data: got %h want %h", if3.o_f_data, seed[0]); end
        if3.i_f_req = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seed[i] = $urandom;
    seed[4] = 32'hDEADBEEF;
    idle_inputs();
    rst = 1'b1;
    #12 rst = 1'b0;
    test_reset();
    test_single_fetch();
    test_data_write();
    test_ignored();
    test_contention();
    test_random(40);
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Sequences and shares the single RAM port between two requesters.
- Fetch port: read only; supplies instruction words to the IR/PC path.
- Data port: read or write; carries LD/LDA/ST traffic using `RAM_NONE/`RAM_READ/`RAM_WRITE encodings.
- Runs one transaction at a time, alternates priority on contention, and returns read data with a one-cycle valid pulse.

Parameters:
AW, 32, address width
DW, 32, data width
RAM_LAT, 1, cycles from command cycle to i_ram_rdata valid; legal 1..15

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_f_req  in  1  fetch request (level)
i_f_addr  in  AW  fetch address
o_f_gnt  out  1  fetch granted, 1-cycle pulse
o_f_valid  out  1  fetch data valid, 1-cycle pulse
o_f_data  out  DW  fetched word
i_d_req  in  1  data request (level)
i_d_action  in  2  `RAM_READ or `RAM_WRITE
i_d_addr  in  AW  data address
i_d_wdata  in  DW  store data
o_d_gnt  out  1  data granted, 1-cycle pulse
o_d_valid  out  1  data transaction complete, 1-cycle pulse
o_d_rdata  out  DW  loaded word
o_ram_action  out  2  command to RAM
o_ram_addr  out  AW  RAM address
o_ram_wdata  out  DW  RAM write data
i_ram_rdata  in  DW  RAM read data
o_busy  out  1  high when state != IDLE

Behaviour:
- All outputs registered.
- Reset values:
  - o_ram_action=`RAM_NONE.
  - o_ram_addr, o_ram_wdata, o_f_data, o_d_rdata = 0.
  - All gnt/valid = 0; o_busy=0; state=IDLE.
  - last_owner=FETCH, so data wins the first tie.
- States: IDLE, CMD, WAIT, RESP.
- Request qualification:
  - Fetch request: i_f_req=1.
  - Data request: i_d_req=1 and i_d_action is `RAM_READ or `RAM_WRITE.
  - Data request with action `RAM_NONE is ignored; no grant.
- IDLE (request sampled in cycle R):
  - One qualified request: grant it.
  - Both qualified: grant the port not equal to last_owner.
  - Neither: stay in IDLE.
- Grant edge (end of R):
  - Capture owner, action, addr, wdata into registers; update last_owner.
  - Next state CMD.
- CMD (cycle C=R+1):
  - Owner's gnt=1.
  - o_ram_action = fetch ? `RAM_READ : i_d_action.
  - o_ram_addr and o_ram_wdata from captured values.
  - Lasts exactly one cycle.
  - Write: next state RESP.
  - Read: next state WAIT with counter=RAM_LAT.
- WAIT:
  - o_ram_action=`RAM_NONE.
  - Counter decrements each cycle.
  - In the cycle where i_ram_rdata is valid (C+RAM_LAT), capture it into the owner's data output and go to RESP.
- RESP (read: C+RAM_LAT+1; write: C+1):
  - Owner's valid=1 for one cycle.
  - Non-owner's data output unchanged.
  - Next state IDLE.
- Latency from request-sampled cycle R:
  - gnt at R+1.
  - Read valid at R+2+RAM_LAT (default R+3).
  - Write valid at R+2.
- Requester obligations:
  - Requester deasserts req in the cycle after it sees valid.
  - Req still high when the arbiter is back in IDLE is a new request. Back-to-back transactions are therefore 1 idle cycle apart (next gnt at valid+2).
  - Req/addr/data changes after the grant edge have no effect on the running transaction.
  - Req deasserted before grant: request is withdrawn.
- o_f_data and o_d_rdata hold their last captured value until the next completing read on that port.
- Write data is never returned; o_d_rdata is unchanged on writes.
- Reset mid-operation:
  - Immediate asynchronous return to reset values; transaction aborted.
  - No valid is issued for it.
  - o_ram_action drops to `RAM_NONE without waiting for a clock.

Test Plan:
- Reset: assert i_rst mid-cycle -> all outputs 0, o_ram_action=`RAM_NONE, o_busy=0, with no clock edge needed.
- Single fetch: RAM_LAT=1, f_req at R with addr 0x10, RAM model returns 0xDEADBEEF -> o_f_gnt and o_ram_action=`RAM_READ with o_ram_addr=0x10 at R+1; o_f_valid=1 with o_f_data=0xDEADBEEF at R+3 only; o_d_valid stays 0.
- Data write: d_req at R, `RAM_WRITE, addr 0x20, wdata 0x12345678 -> o_ram_action=`RAM_WRITE for exactly cycle R+1; o_d_valid at R+2; o_d_rdata unchanged.
- Contention: after reset, f_req and d_req held continuously -> grant order data, fetch, data, fetch; each transaction is complete before the next grant.
- Ignored request: d_req=1 with `RAM_NONE for 5 cycles -> no gnt, o_busy=0.
- Reset mid-WAIT: RAM_LAT=3, fetch granted, i_rst pulsed in WAIT -> no o_f_valid; after release a new fetch to 0x40 completes normally at R+5.
